// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for the multi-cycle RV32I controller.
// The controller side is the master; the datapath and memory side is the slave.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       mem_ready;
  logic       br_eq;
  logic       br_lt;
  logic       br_ltu;

  logic       pc_we;
  logic       pc_src;
  logic       ir_we;
  logic       adr_src;
  logic       mem_req;
  logic       mem_we;
  logic [1:0] mem_size;
  logic       rf_we;
  logic [1:0] alu_a_sel;
  logic [1:0] alu_b_sel;
  logic [3:0] alu_ctrl;
  logic [1:0] result_sel;
  logic       retire;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct3, funct7, mem_ready, br_eq, br_lt, br_ltu,
    output pc_we, pc_src, ir_we, adr_src, mem_req, mem_we, mem_size, rf_we,
           alu_a_sel, alu_b_sel, alu_ctrl, result_sel, retire, illegal, state
  );

  modport slave (
    output opcode, funct3, funct7, mem_ready, br_eq, br_lt, br_ltu,
    input  pc_we, pc_src, ir_we, adr_src, mem_req, mem_we, mem_size, rf_we,
           alu_a_sel, alu_b_sel, alu_ctrl, result_sel, retire, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/write-back
// over one memory port and one ALU, and flags illegal encodings.
module multicycle_ctrl #(
  parameter bit STRICT_DECODE = 1'b1
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StExecR, StExecI, StMemAdr, StMemRd, StMemWr,
    StWbMem, StWbAlu, StBranch, StJalrAdr, StJump, StUpper, StTrap
  } state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  state_e state_q, state_d;
  state_e dec_next;
  logic   legal;
  logic   cond;
  logic   taken;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    unique case (f3)
      3'b000: alu_op = alt ? 4'd1 : 4'd0;
      3'b001: alu_op = 4'd2;
      3'b010: alu_op = 4'd3;
      3'b011: alu_op = 4'd4;
      3'b100: alu_op = 4'd5;
      3'b101: alu_op = alt ? 4'd7 : 4'd6;
      3'b110: alu_op = 4'd8;
      3'b111: alu_op = 4'd9;
    endcase
  endfunction

  always_comb begin
    legal    = 1'b1;
    dec_next = StTrap;
    case (bus.opcode)
      OpR: begin
        dec_next = StExecR;
        legal    = (bus.funct7 == 7'h00) ||
                   (bus.funct7 == 7'h20 && (bus.funct3 == 3'b000 || bus.funct3 == 3'b101));
      end
      OpImm: begin
        dec_next = StExecI;
        if (bus.funct3 == 3'b001) begin
          legal = (bus.funct7 == 7'h00);
        end else if (bus.funct3 == 3'b101) begin
          legal = (bus.funct7 == 7'h00) || (bus.funct7 == 7'h20);
        end
      end
      OpLoad: begin
        dec_next = StMemAdr;
        legal    = !(bus.funct3 == 3'b011 || bus.funct3[2:1] == 2'b11);
      end
      OpStore: begin
        dec_next = StMemAdr;
        legal    = (bus.funct3 <= 3'b010);
      end
      OpBranch: begin
        dec_next = StBranch;
        legal    = (bus.funct3[2:1] != 2'b01);
      end
      OpJal:          dec_next = StJump;
      OpJalr: begin
        dec_next = StJalrAdr;
        legal    = (bus.funct3 == 3'b000);
      end
      OpLui, OpAuipc: dec_next = StUpper;
      default:        legal = 1'b0;
    endcase
  end

  // funct3[0] selects the negated form of each comparison (BNE, BGE, BGEU).
  always_comb begin
    unique case (bus.funct3[2:1])
      2'b00:   cond = bus.br_eq;
      2'b10:   cond = bus.br_lt;
      2'b11:   cond = bus.br_ltu;
      default: cond = 1'b0;
    endcase
    taken = cond ^ bus.funct3[0];
  end

  always_comb begin
    state_d        = state_q;
    bus.pc_we      = 1'b0;
    bus.pc_src     = 1'b0;
    bus.ir_we      = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_size   = 2'd2;
    bus.rf_we      = 1'b0;
    bus.alu_a_sel  = 2'd0;
    bus.alu_b_sel  = 2'd0;
    bus.alu_ctrl   = 4'd0;
    bus.result_sel = 2'd0;
    bus.retire     = 1'b0;
    bus.illegal    = 1'b0;
    bus.state      = StFetch;
    // Reset masks every output, so an in-flight memory access is dropped at once.
    if (!rst) begin
      bus.state = state_q;
      unique case (state_q)
        StFetch: begin
          bus.mem_req    = 1'b1;
          bus.alu_b_sel  = 2'd2;
          bus.result_sel = 2'd2;
          if (bus.mem_ready) begin
            bus.ir_we = 1'b1;
            bus.pc_we = 1'b1;
            state_d   = StDecode;
          end
        end
        StDecode: begin
          bus.alu_a_sel = 2'd1;
          bus.alu_b_sel = 2'd1;
          if (legal) begin
            state_d = dec_next;
          end else if (STRICT_DECODE) begin
            state_d = StTrap;
          end else begin
            state_d    = StFetch;
            bus.retire = 1'b1;
          end
        end
        StExecR: begin
          bus.alu_a_sel = 2'd2;
          bus.alu_ctrl  = alu_op(bus.funct3, bus.funct7[5]);
          state_d       = StWbAlu;
        end
        StExecI: begin
          bus.alu_a_sel = 2'd2;
          bus.alu_b_sel = 2'd1;
          bus.alu_ctrl  = alu_op(bus.funct3, bus.funct3 == 3'b101 && bus.funct7[5]);
          state_d       = StWbAlu;
        end
        StMemAdr: begin
          bus.alu_a_sel = 2'd2;
          bus.alu_b_sel = 2'd1;
          state_d       = bus.opcode[5] ? StMemWr : StMemRd;
        end
        StMemRd: begin
          bus.mem_req  = 1'b1;
          bus.adr_src  = 1'b1;
          bus.mem_size = bus.funct3[1:0];
          if (bus.mem_ready) state_d = StWbMem;
        end
        StMemWr: begin
          bus.mem_req  = 1'b1;
          bus.mem_we   = 1'b1;
          bus.adr_src  = 1'b1;
          bus.mem_size = bus.funct3[1:0];
          if (bus.mem_ready) begin
            bus.retire = 1'b1;
            state_d    = StFetch;
          end
        end
        StWbMem: begin
          bus.rf_we      = 1'b1;
          bus.result_sel = 2'd1;
          bus.retire     = 1'b1;
          state_d        = StFetch;
        end
        StWbAlu: begin
          bus.rf_we  = 1'b1;
          bus.retire = 1'b1;
          state_d    = StFetch;
        end
        StBranch: begin
          bus.alu_a_sel = 2'd2;
          bus.alu_ctrl  = 4'd1;
          bus.pc_src    = 1'b1;
          bus.pc_we     = taken;
          bus.retire    = 1'b1;
          state_d       = StFetch;
        end
        StJalrAdr: begin
          bus.alu_a_sel = 2'd2;
          bus.alu_b_sel = 2'd1;
          state_d       = StJump;
        end
        StJump: begin
          bus.alu_a_sel  = 2'd1;
          bus.alu_b_sel  = 2'd2;
          bus.result_sel = 2'd2;
          bus.rf_we      = 1'b1;
          bus.pc_we      = 1'b1;
          bus.pc_src     = 1'b1;
          bus.retire     = 1'b1;
          state_d        = StFetch;
        end
        StUpper: begin
          bus.alu_a_sel  = (bus.opcode == OpLui) ? 2'd3 : 2'd1;
          bus.alu_b_sel  = 2'd1;
          bus.result_sel = 2'd2;
          bus.rf_we      = 1'b1;
          bus.retire     = 1'b1;
          state_d        = StFetch;
        end
        StTrap:  bus.illegal = 1'b1;
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

endmodule
